// File: rtl/dino_pkg.sv
// Shared types and default tuning for the dino game obstacle path.
package dino_pkg;

   localparam int unsigned RND_W_DEF      = 5;
   localparam int unsigned MIN_GAP_DEF    = 40;
   localparam int unsigned GAP_SHIFT_DEF  = 2;
   localparam int unsigned MAX_ACTIVE_DEF = 3;
   localparam int unsigned TYPE_W_DEF     = 2;

   typedef enum logic [2:0] {
      IDLE,
      DRAW,
      LATCH,
      WAIT,
      OFFER,
      HALT
   } sched_state_t;

   typedef logic [TYPE_W_DEF-1:0] cactus_type_t;

   // Width needed to hold the largest gap a full-scale RNG draw can produce.
   function automatic int unsigned gap_width(input int unsigned rnd_w,
                                             input int unsigned min_gap,
                                             input int unsigned gap_shift);
      return $clog2(min_gap + (((1 << rnd_w) - 1) << gap_shift) + 1);
   endfunction

endpackage

// File: rtl/obstacle_scheduler_gap_timer.sv
// Loadable down-counter that counts enabled ticks toward zero and flags arrival.
module gap_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   input  logic         clr,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (tick && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/obstacle_scheduler.sv
// Cactus spawn sequencer: draws the RNG, waits out the gap, offers a spawn
// to the renderer and keeps the on-screen obstacle count capped.
module obstacle_scheduler
   import dino_pkg::*;
#(
   parameter int unsigned RND_W      = RND_W_DEF,
   parameter int unsigned MIN_GAP    = MIN_GAP_DEF,
   parameter int unsigned GAP_SHIFT  = GAP_SHIFT_DEF,
   parameter int unsigned MAX_ACTIVE = MAX_ACTIVE_DEF,
   parameter int unsigned TYPE_W     = TYPE_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              game_run,
   input  logic              game_over,
   input  logic [RND_W-1:0]  rnd_in,
   output logic              rnd_step,
   output logic              spawn_valid,
   input  logic              spawn_ready,
   output logic [TYPE_W-1:0] spawn_type,
   input  logic              obs_retire,
   output logic [1:0]        active_cnt
);

   localparam int unsigned GAP_W = gap_width(RND_W, MIN_GAP, GAP_SHIFT);
   localparam logic [1:0]  MAX_A = 2'(MAX_ACTIVE);

   sched_state_t      state, state_next;
   logic [TYPE_W-1:0] type_q;
   logic [TYPE_W-1:0] spawn_type_d;
   logic              rnd_step_d, spawn_valid_d;
   logic [GAP_W-1:0]  load_val;
   logic              gap_zero, clr, handshake, retire_ok;

   // game_over outranks game_run, so a stop request only clears when no collision is pending.
   assign clr       = !game_over && !game_run;
   assign handshake = (state == OFFER) && spawn_ready && game_run && !game_over;
   assign retire_ok = obs_retire && (state != HALT) && (active_cnt != '0) && !game_over;
   assign load_val  = GAP_W'(MIN_GAP) + (GAP_W'(rnd_in) << GAP_SHIFT);

   gap_timer #(
      .W (GAP_W)
   ) u_gap_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == LATCH),
      .load_val (load_val),
      .tick     (tick && (state == WAIT)),
      .clr      (clr),
      .zero     (gap_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (game_over) begin
         state_next = HALT;
      end else if (!game_run) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = DRAW;
            DRAW:    state_next = LATCH;
            LATCH:   state_next = WAIT;
            WAIT:    if (gap_zero && (active_cnt < MAX_A)) state_next = OFFER;
            OFFER:   if (spawn_ready) state_next = DRAW;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so the registered copies line up with the state.
   always_comb begin
      rnd_step_d    = (state_next == DRAW);
      spawn_valid_d = (state_next == OFFER);
      spawn_type_d  = spawn_valid_d ? type_q : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rnd_step    <= 1'b0;
         spawn_valid <= 1'b0;
         spawn_type  <= '0;
         type_q      <= '0;
         active_cnt  <= '0;
      end else begin
         rnd_step    <= rnd_step_d;
         spawn_valid <= spawn_valid_d;
         spawn_type  <= spawn_type_d;
         if (clr) begin
            type_q     <= '0;
            active_cnt <= '0;
         end else begin
            if (state == LATCH) begin
               type_q <= rnd_in[TYPE_W-1:0] ^ rnd_in[RND_W-1 -: TYPE_W];
            end
            if (handshake) begin
               if (!obs_retire) active_cnt <= active_cnt + 2'd1;
            end else if (retire_ok) begin
               active_cnt <= active_cnt - 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed-random bench for obstacle_scheduler against a gap/type/count model.
module tb_obstacle_scheduler;
   import dino_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         tick = 1'b0;
   logic         game_run = 1'b0;
   logic         game_over = 1'b0;
   logic         spawn_ready = 1'b0;
   logic         obs_retire = 1'b0;
   logic [4:0]   rnd_in = '0;
   logic         rnd_step, spawn_valid;
   cactus_type_t spawn_type;
   logic [1:0]   active_cnt;

   int total = 0;
   int bad = 0;
   int exp_active = 0;

   obstacle_scheduler #(
      .RND_W      (5),
      .MIN_GAP    (40),
      .GAP_SHIFT  (2),
      .MAX_ACTIVE (3),
      .TYPE_W     (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .game_run    (game_run),
      .game_over   (game_over),
      .rnd_in      (rnd_in),
      .rnd_step    (rnd_step),
      .spawn_valid (spawn_valid),
      .spawn_ready (spawn_ready),
      .spawn_type  (spawn_type),
      .obs_retire  (obs_retire),
      .active_cnt  (active_cnt)
   );

   always #5 clk = ~clk;

   function automatic int gap_of(input int r);
      return 40 + r * 4;
   endfunction

   function automatic int type_of(input int r);
      return (r % 4) ^ (r / 8);
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic draw(input int r, input bit retire);
      int waited = 0;
      while (rnd_step !== 1'b1 && waited < 8) begin
         step();
         waited++;
      end
      chk("rnd_step_seen", 32'(rnd_step), 1);
      rnd_in = 5'(r);
      obs_retire = retire;
      step();
      obs_retire = 1'b0;
      if (retire && exp_active > 0) exp_active--;
      chk("rnd_step_pulse", 32'(rnd_step), 0);
      chk("active_after_draw", 32'(active_cnt), exp_active);
      step();
      rnd_in = 5'($urandom);
   endtask

   task automatic run_gap(input int lim, output int n);
      n = 0;
      while (n < lim && spawn_valid !== 1'b1) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         step();
         n++;
      end
   endtask

   task automatic spawn_gap(input int r);
      int n;
      run_gap(200, n);
      chk("gap_ticks", n, gap_of(r));
      chk("spawn_valid_up", 32'(spawn_valid), 1);
      chk("spawn_type", 32'(spawn_type), type_of(r));
   endtask

   task automatic handshake(input int hold, input bit retire, input int r);
      for (int i = 0; i < hold; i++) begin
         step();
         chk("hold_valid", 32'(spawn_valid), 1);
         chk("hold_type", 32'(spawn_type), type_of(r));
      end
      spawn_ready = 1'b1;
      obs_retire = retire;
      step();
      spawn_ready = 1'b0;
      obs_retire = 1'b0;
      if (!retire) exp_active++;
      chk("active_after_hs", 32'(active_cnt), exp_active);
      chk("valid_drop", 32'(spawn_valid), 0);
   endtask

   initial begin
      int r;
      int n;

      step();
      step();
      chk("rst_rnd_step", 32'(rnd_step), 0);
      chk("rst_valid", 32'(spawn_valid), 0);
      chk("rst_type", 32'(spawn_type), 0);
      chk("rst_active", 32'(active_cnt), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("idle_no_step", 32'(rnd_step), 0);
      end

      game_run = 1'b1;
      draw(3, 1'b0);
      spawn_gap(3);
      handshake(0, 1'b0, 3);

      draw(31, 1'b0);
      spawn_gap(31);
      handshake(10, 1'b1, 31);

      for (int k = 0; k < 2; k++) begin
         r = int'($urandom_range(0, 31));
         draw(r, 1'b0);
         spawn_gap(r);
         handshake(int'($urandom_range(0, 3)), 1'b0, r);
      end

      // cap reached: gap expires but the spawn must wait for a retire
      r = int'($urandom_range(0, 31));
      draw(r, 1'b0);
      run_gap(gap_of(r), n);
      chk("defer_ticks", n, gap_of(r));
      tick = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("deferred_valid", 32'(spawn_valid), 0);
      end
      tick = 1'b0;
      obs_retire = 1'b1;
      step();
      obs_retire = 1'b0;
      exp_active--;
      chk("retire_in_wait", 32'(active_cnt), exp_active);
      n = 0;
      while (spawn_valid !== 1'b1 && n < 2) begin
         step();
         n++;
      end
      chk("release_valid", 32'(spawn_valid), 1);
      chk("release_type", 32'(spawn_type), type_of(r));
      handshake(0, 1'b0, r);

      r = int'($urandom_range(0, 31));
      draw(r, 1'b1);
      obs_retire = 1'b1;
      step();
      obs_retire = 1'b0;
      exp_active--;
      chk("retire_wait2", 32'(active_cnt), exp_active);
      spawn_gap(r);
      game_over = 1'b1;
      step();
      game_over = 1'b0;
      chk("over_valid", 32'(spawn_valid), 0);
      chk("over_type", 32'(spawn_type), 0);
      chk("over_active", 32'(active_cnt), exp_active);
      chk("over_rnd_step", 32'(rnd_step), 0);
      obs_retire = 1'b1;
      step();
      obs_retire = 1'b0;
      chk("halt_retire", 32'(active_cnt), exp_active);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("halt_rnd_step", 32'(rnd_step), 0);
         chk("halt_valid", 32'(spawn_valid), 0);
      end
      game_run = 1'b0;
      step();
      exp_active = 0;
      chk("run_off_clear", 32'(active_cnt), 0);

      game_run = 1'b1;
      r = int'($urandom_range(0, 31));
      draw(r, 1'b1);
      spawn_gap(r);
      handshake(0, 1'b0, r);

      r = int'($urandom_range(0, 31));
      draw(r, 1'b0);
      run_gap(gap_of(r) - 17, n);
      chk("pre_reset_ticks", n, gap_of(r) - 17);
      chk("pre_reset_active", 32'(active_cnt), exp_active);
      #2;
      rst_n = 1'b0;
      game_run = 1'b0;
      #1;
      exp_active = 0;
      chk("arst_rnd_step", 32'(rnd_step), 0);
      chk("arst_valid", 32'(spawn_valid), 0);
      chk("arst_type", 32'(spawn_type), 0);
      chk("arst_active", 32'(active_cnt), 0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("post_reset_idle", 32'(rnd_step), 0);
      end

      game_run = 1'b1;
      r = int'($urandom_range(0, 31));
      draw(r, 1'b0);
      spawn_gap(r);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_offer_valid", 32'(spawn_valid), 0);
      chk("arst_offer_type", 32'(spawn_type), 0);
      step();
      game_run = 1'b0;
      rst_n = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
